// File: rtl/ebn_buf.sv
// ebn_buf: N-entry elastic valid/ready buffer; handshake outputs depend only on registered state.
// Optional occupancy port `level` is present when EBN_LEVEL_EN is defined.
module ebn_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] t_0_data,
    input  logic             t_0_valid,
    output logic             t_0_ready,
    output logic [WIDTH-1:0] i_0_data,
    output logic             i_0_valid,
    input  logic             i_0_ready
`ifdef EBN_LEVEL_EN
    ,
    output logic [LW-1:0]    level
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] CntFull = LW'(DEPTH);
    localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    // Gating by reset_n keeps both sides idle while reset is held, whatever count_q holds.
    assign t_0_ready = reset_n & (count_q != CntFull);
    assign i_0_valid = reset_n & (count_q != '0);
    assign i_0_data  = mem_q[rd_ptr_q];

    assign push = t_0_valid & t_0_ready;
    assign pop  = i_0_valid & i_0_ready;

`ifdef EBN_LEVEL_EN
    assign level = reset_n ? count_q : '0;
`endif

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; push is already suppressed during reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= t_0_data;
        end
    end

endmodule

// File: tb/tb_ebn_buf.sv
// Scoreboard bench for ebn_buf: a DEPTH=3 and a DEPTH=1 instance checked against queue models.
module tb_ebn_buf;
    localparam int W   = 8;
    localparam int D0  = 3;
    localparam int D1  = 1;
    localparam int LW0 = $clog2(D0 + 1);
    localparam int LW1 = $clog2(D1 + 1);

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] td0, td1, id0, id1;
    logic         tv0, tv1, tr0, tr1, iv0, iv1, ir0, ir1;
`ifdef EBN_LEVEL_EN
    logic [LW0-1:0] lv0;
    logic [LW1-1:0] lv1;
`endif

    always #5 clk = ~clk;

    ebn_buf #(.WIDTH(W), .DEPTH(D0)) u_d3 (
        .clk(clk), .reset_n(reset_n),
        .t_0_data(td0), .t_0_valid(tv0), .t_0_ready(tr0),
        .i_0_data(id0), .i_0_valid(iv0), .i_0_ready(ir0)
`ifdef EBN_LEVEL_EN
        , .level(lv0)
`endif
    );

    ebn_buf #(.WIDTH(W), .DEPTH(D1)) u_d1 (
        .clk(clk), .reset_n(reset_n),
        .t_0_data(td1), .t_0_valid(tv1), .t_0_ready(tr1),
        .i_0_data(id1), .i_0_valid(iv1), .i_0_ready(ir1)
`ifdef EBN_LEVEL_EN
        , .level(lv1)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit pushed0 = 1'b0;
    bit pushed1 = 1'b0;
    bit hold0 = 1'b0;
    bit hold1 = 1'b0;
    logic [W-1:0] hdat0, hdat1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a buffer is a FIFO of at most DEPTH words, cleared by reset.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                q0.delete();
                q1.delete();
                pushed0 = 1'b0;
                pushed1 = 1'b0;
            end else begin
                pushed0 = tv0 && (q0.size() < D0);
                if (ir0 && q0.size() != 0) void'(q0.pop_front());
                if (pushed0) q0.push_back(td0);
                pushed1 = tv1 && (q1.size() < D1);
                if (ir1 && q1.size() != 0) void'(q1.pop_front());
                if (pushed1) q1.push_back(td1);
            end
        end
    end

    // Monitor: compare handshake and head data against the model away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("ready_d3", {31'b0, tr0}, {31'b0, reset_n && (q0.size() < D0)});
            chk("valid_d3", {31'b0, iv0}, {31'b0, reset_n && (q0.size() != 0)});
            if (iv0 && reset_n && q0.size() != 0) chk("data_d3", {24'b0, id0}, {24'b0, q0[0]});
            chk("ready_d1", {31'b0, tr1}, {31'b0, reset_n && (q1.size() < D1)});
            chk("valid_d1", {31'b0, iv1}, {31'b0, reset_n && (q1.size() != 0)});
            if (iv1 && reset_n && q1.size() != 0) chk("data_d1", {24'b0, id1}, {24'b0, q1[0]});
`ifdef EBN_LEVEL_EN
            chk("level_d3", {{(32-LW0){1'b0}}, lv0}, reset_n ? q0.size() : 0);
            chk("level_d1", {{(32-LW1){1'b0}}, lv1}, reset_n ? q1.size() : 0);
`endif
            if (reset_n && hold0 && iv0) chk("hold_d3", {24'b0, id0}, {24'b0, hdat0});
            if (reset_n && hold1 && iv1) chk("hold_d1", {24'b0, id1}, {24'b0, hdat1});
            hold0 = reset_n && iv0 && !ir0;
            hdat0 = id0;
            hold1 = reset_n && iv1 && !ir1;
            hdat1 = id1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [W-1:0] d, output int cyc);
        td0 = d;
        tv0 = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!pushed0 && cyc < 50);
        if (!pushed0) chk("send_d3_timeout", 32'd0, 32'd1);
        tv0 = 1'b0;
    endtask

    task automatic send1(input logic [W-1:0] d, output int cyc);
        td1 = d;
        tv1 = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!pushed1 && cyc < 50);
        if (!pushed1) chk("send_d1_timeout", 32'd0, 32'd1);
        tv1 = 1'b0;
    endtask

    task automatic drain_all();
        int n;
        tv0 = 1'b0;
        tv1 = 1'b0;
        ir0 = 1'b1;
        ir1 = 1'b1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", q0.size() + q1.size(), 0);
    endtask

    initial begin
        int c, tot;
        reset_n = 1'b0;
        tv0 = 1'b1; td0 = 8'hAA; ir0 = 1'b0;
        tv1 = 1'b0; td1 = 8'h00; ir1 = 1'b0;

        // Reset held for two clocks with a pending producer word.
        step();
        step();
        chk("rst_ready", {31'b0, tr0}, 32'd0);
        chk("rst_valid", {31'b0, iv0}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, tr0}, 32'd1);
        step();
        tv0 = 1'b0;
        drain_all();

        // Fill and drain.
        ir0 = 1'b0;
        send0(8'h11, c);
        send0(8'h22, c);
        send0(8'h33, c);
        chk("full_ready", {31'b0, tr0}, 32'd0);
        ir0 = 1'b1;
        step();
        step();
        step();
        chk("drained_valid", {31'b0, iv0}, 32'd0);

        // Streaming at one word per clock.
        tot = 0;
        for (int i = 0; i < 10; i++) begin
            send0(i[7:0], c);
            tot += c;
        end
        chk("stream_rate", tot, 10);
        drain_all();

        // Pointer wrap with continuous push/pop.
        for (int i = 0; i < 7; i++) send0(8'($urandom), c);
        drain_all();

        // Full with simultaneous pop: pop only, freed slot offered next cycle.
        ir0 = 1'b0;
        for (int i = 0; i < 3; i++) send0(8'($urandom), c);
        td0 = 8'h44;
        tv0 = 1'b1;
        ir0 = 1'b1;
        step();
        chk("full_pop_no_push", {31'b0, pushed0}, 32'd0);
        step();
        chk("full_next_push", {31'b0, pushed0}, 32'd1);
        tv0 = 1'b0;
        drain_all();

        // DEPTH=1 alternates acceptance.
        ir1 = 1'b1;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send1(8'($urandom), c);
            tot += c;
        end
        chk("d1_rate", tot, 15);
        drain_all();

        // Reset with two words stored: they must never appear.
        ir0 = 1'b0;
        send0(8'hE1, c);
        send0(8'hE2, c);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        chk("rst_mid_valid", {31'b0, iv0}, 32'd0);
        send0(8'h5A, c);
        ir0 = 1'b1;
        #1;
        chk("after_rst_head", {24'b0, id0}, 32'h5A);
        drain_all();

        // Randomized traffic on both instances with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if (!tv0 || pushed0) begin
                tv0 = ($urandom_range(0, 3) != 0);
                td0 = 8'($urandom);
            end
            if (!tv1 || pushed1) begin
                tv1 = ($urandom_range(0, 3) != 0);
                td1 = 8'($urandom);
            end
            ir0 = ($urandom_range(0, 2) != 0);
            ir1 = ($urandom_range(0, 2) != 0);
            reset_n = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1'b1;
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
